// File: rtl/freq_div_prog_if.sv
// Purpose: control/status bundle for the programmable frequency divider.
// Latency: none (wiring only).
// Backpressure: none; the load strobe is always accepted.
// Ports (master = controller side, slave = divider side):
//   en, load, half_period, mode : controller -> divider
//   clk_div, tick, pend         : divider -> controller
interface freq_div_prog_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             load;
  logic [CNT_W-1:0] half_period;
  logic             mode;
  logic             clk_div;
  logic             tick;
  logic             pend;

  modport master (
    output en, load, half_period, mode,
    input  clk_div, tick, pend
  );

  modport slave (
    input  en, load, half_period, mode,
    output clk_div, tick, pend
  );
endinterface

// File: rtl/freq_div_prog.sv
// Purpose: programmable clock divider (square wave or single-cycle pulse) with
//          glitch-free ratio switching at counter boundaries.
// Latency: outputs registered, one clk_ref edge after the terminal count.
// Backpressure: none; en low freezes counting, load is always accepted.
// Ports:
//   clk_ref : reference clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : freq_div_prog_if.slave (en, load, half_period, mode in;
//             clk_div, tick, pend out)
module freq_div_prog #(
  parameter int CNT_W    = 16,
  parameter int DEF_HALF = 50
) (
  input  logic                 clk_ref,
  input  logic                 rst,
  freq_div_prog_if.slave       bus
);

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEF_VAL  = CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_act_half;
  logic             r_act_mode;
  logic [CNT_W-1:0] r_pend_half;
  logic             r_pend_mode;
  logic             r_pend;
  logic             r_clk_div;
  logic             r_tick;

  logic [CNT_W-1:0] w_last;
  logic             w_term;
  logic [CNT_W-1:0] w_nxt_half;
  logic             w_nxt_mode;

  // A half-period of 0 behaves like 1: the last count is 0 either way.
  assign w_last = (r_act_half == '0) ? '0 : (r_act_half - ONE);
  assign w_term = bus.en && (r_cnt == w_last);

  // Ratio in force after a terminal: a coincident load beats an older
  // pending ratio, which beats keeping the current one.
  assign w_nxt_half = bus.load ? bus.half_period : (r_pend ? r_pend_half : r_act_half);
  assign w_nxt_mode = bus.load ? bus.mode        : (r_pend ? r_pend_mode : r_act_mode);

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_cnt       <= '0;
      r_act_half  <= DEF_VAL;
      r_act_mode  <= 1'b0;
      r_pend_half <= '0;
      r_pend_mode <= 1'b0;
      r_pend      <= 1'b0;
      r_clk_div   <= 1'b0;
      r_tick      <= 1'b0;
    end else if (bus.load && !bus.en) begin
      // Divider is idle, so the new ratio can be applied straight away.
      r_act_half <= bus.half_period;
      r_act_mode <= bus.mode;
      r_cnt      <= '0;
      r_clk_div  <= 1'b0;
      r_tick     <= 1'b0;
      r_pend     <= 1'b0;
    end else if (bus.en) begin
      r_tick <= w_term;
      if (w_term) begin
        r_cnt      <= '0;
        r_act_half <= w_nxt_half;
        r_act_mode <= w_nxt_mode;
        r_pend     <= 1'b0;
        if (w_nxt_mode)
          r_clk_div <= 1'b1;        // pulse mode: clk_div mirrors tick
        else if (r_act_mode)
          r_clk_div <= 1'b0;        // leaving pulse mode: square wave starts low
        else
          r_clk_div <= ~r_clk_div;
      end else begin
        r_cnt <= r_cnt + ONE;
        if (r_act_mode)
          r_clk_div <= 1'b0;
        if (bus.load) begin
          // Later loads simply overwrite; only the last one reaches a boundary.
          r_pend_half <= bus.half_period;
          r_pend_mode <= bus.mode;
          r_pend      <= 1'b1;
        end
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign bus.clk_div = r_clk_div;
  assign bus.tick    = r_tick;
  assign bus.pend    = r_pend;

endmodule

// File: tb/tb_freq_div_prog.sv
// Purpose: directed self-checking bench for freq_div_prog.
// Latency: inputs change 1ns after a rising edge, outputs sampled at that point.
// Backpressure: not applicable.
module tb_freq_div_prog;

  localparam int CNT_W = 16;

  logic clk_ref;
  logic rst;
  int   n_checks;
  int   n_errors;

  freq_div_prog_if #(.CNT_W(CNT_W)) ifc ();

  freq_div_prog #(.CNT_W(CNT_W), .DEF_HALF(50)) dut (
    .clk_ref (clk_ref),
    .rst     (rst),
    .bus     (ifc.slave)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  // Advance n rising edges; afterwards we sit 1ns past the last edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_ref);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic cd, input logic tk, input logic pd);
    chk({tag, ".clk_div"}, ifc.clk_div, cd);
    chk({tag, ".tick"},    ifc.tick,    tk);
    chk({tag, ".pend"},    ifc.pend,    pd);
  endtask

  task automatic do_load(input logic [CNT_W-1:0] hp, input logic md);
    ifc.load        = 1'b1;
    ifc.half_period = hp;
    ifc.mode        = md;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    ifc.en          = 1'b0;
    ifc.load        = 1'b0;
    ifc.half_period = '0;
    ifc.mode        = 1'b0;
    run(2);
    chk3("reset", 1'b0, 1'b0, 1'b0);

    // Default divide-by-100
    rst = 1'b0; ifc.en = 1'b1;
    run(49); chk3("def_e49",  1'b0, 1'b0, 1'b0);
    run(1);  chk3("def_e50",  1'b1, 1'b1, 1'b0);
    run(1);  chk3("def_e51",  1'b1, 1'b0, 1'b0);
    run(49); chk3("def_e100", 1'b0, 1'b1, 1'b0);

    // Load 3 at cnt=10, applies at the cnt=49 wrap
    run(10);
    do_load(16'd3, 1'b0);
    run(1);  ifc.load = 1'b0;
    chk3("ld3_cap", 1'b0, 1'b0, 1'b1);
    run(38); chk3("ld3_wait", 1'b0, 1'b0, 1'b1);
    run(1);  chk3("ld3_sw",   1'b1, 1'b1, 1'b0);
    run(2);  chk3("ld3_mid",  1'b1, 1'b0, 1'b0);
    run(1);  chk3("ld3_t1",   1'b0, 1'b1, 1'b0);
    run(3);  chk3("ld3_t2",   1'b1, 1'b1, 1'b0);

    // Load 7 then 5 before the boundary: only 5 applies
    do_load(16'd7, 1'b0);
    run(1);  chk3("ld7", 1'b1, 1'b0, 1'b1);
    do_load(16'd5, 1'b0);
    run(1);  ifc.load = 1'b0;
    chk3("ld5", 1'b1, 1'b0, 1'b1);
    run(1);  chk3("ld5_sw",  1'b0, 1'b1, 1'b0);
    run(4);  chk3("ld5_mid", 1'b0, 1'b0, 1'b0);
    run(1);  chk3("ld5_t1",  1'b1, 1'b1, 1'b0);
    run(5);  chk3("ld5_t2",  1'b0, 1'b1, 1'b0);

    // Load coincident with terminal takes effect at once, pend stays low
    run(4);
    do_load(16'd2, 1'b0);
    run(1);  ifc.load = 1'b0;
    chk3("coinc_sw", 1'b1, 1'b1, 1'b0);
    run(1);  chk3("coinc_mid", 1'b1, 1'b0, 1'b0);
    run(1);  chk3("coinc_t1",  1'b0, 1'b1, 1'b0);

    // Load 4 pulse mode with en low, then run
    ifc.en = 1'b0;
    do_load(16'd4, 1'b1);
    run(1);  chk3("p4_ld", 1'b0, 1'b0, 1'b0);
    ifc.load = 1'b0; ifc.en = 1'b1;
    run(3);  chk3("p4_e3", 1'b0, 1'b0, 1'b0);
    run(1);  chk3("p4_e4", 1'b1, 1'b1, 1'b0);
    run(1);  chk3("p4_e5", 1'b0, 1'b0, 1'b0);
    run(3);  chk3("p4_e8", 1'b1, 1'b1, 1'b0);

    // Pulse -> square switch at a boundary starts low
    do_load(16'd2, 1'b0);
    run(1);  ifc.load = 1'b0;
    chk3("m10_cap", 1'b0, 1'b0, 1'b1);
    run(2);  chk3("m10_wait", 1'b0, 1'b0, 1'b1);
    run(1);  chk3("m10_sw",   1'b0, 1'b1, 1'b0);
    run(2);  chk3("m10_t1",   1'b1, 1'b1, 1'b0);

    // half_period 0, square mode: toggle every enabled cycle; en freeze
    ifc.en = 1'b0;
    do_load(16'd0, 1'b0);
    run(1);  chk3("h0_ld", 1'b0, 1'b0, 1'b0);
    ifc.load = 1'b0; ifc.en = 1'b1;
    run(1);  chk3("h0_c1", 1'b1, 1'b1, 1'b0);
    run(1);  chk3("h0_c2", 1'b0, 1'b1, 1'b0);
    run(1);  chk3("h0_c3", 1'b1, 1'b1, 1'b0);
    ifc.en = 1'b0;
    run(1);  chk3("h0_frz1", 1'b1, 1'b0, 1'b0);
    run(2);  chk3("h0_frz3", 1'b1, 1'b0, 1'b0);
    ifc.en = 1'b1;
    run(1);  chk3("h0_res", 1'b0, 1'b1, 1'b0);

    // half_period 0, pulse mode: clk_div stays high while enabled
    ifc.en = 1'b0;
    do_load(16'd0, 1'b1);
    run(1);  chk3("h0p_ld", 1'b0, 1'b0, 1'b0);
    ifc.load = 1'b0; ifc.en = 1'b1;
    run(1);  chk3("h0p_c1", 1'b1, 1'b1, 1'b0);
    run(1);  chk3("h0p_c2", 1'b1, 1'b1, 1'b0);

    // Reset mid-period with a pending ratio
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(20);
    do_load(16'd9, 1'b0);
    run(1);  ifc.load = 1'b0;
    chk3("rst_pend", 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    run(1);  chk3("rst_hit", 1'b0, 1'b0, 1'b0);
    do_load(16'd3, 1'b0);
    run(1);  chk3("rst_ovr", 1'b0, 1'b0, 1'b0);
    rst = 1'b0; ifc.load = 1'b0;
    run(49); chk3("rst_e49", 1'b0, 1'b0, 1'b0);
    run(1);  chk3("rst_e50", 1'b1, 1'b1, 1'b0);

    // en low mid-period: resume continues from the held count
    run(10);
    ifc.en = 1'b0;
    run(5);  chk3("hold", 1'b1, 1'b0, 1'b0);
    ifc.en = 1'b1;
    run(39); chk3("hold_e39", 1'b1, 1'b0, 1'b0);
    run(1);  chk3("hold_e40", 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
